// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : inst_rom_arbiter
// Purpose  : Two-port arbiter for the instruction ROM read port. The fetch
//            port has priority; a burst limit guarantees debug-port progress.
//            Define INST_ROM_ARB_ADDR_CHECK_EN to flag misaligned or
//            out-of-range addresses as error accesses.
// Revision : 1.0 - initial release
// ============================================================================
module inst_rom_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);

  localparam logic [31:0] c_ZERO_WORD         = 32'h0000_0000;
  localparam logic        c_CHIP_ENABLE       = 1'b1;
  localparam logic        c_CHIP_DISABLE      = 1'b0;
  localparam int          c_INST_MEM_NUM_LOG2 = 17;
  localparam logic [3:0]  c_MAX_BURST         = 4'(MAX_BURST);
  localparam logic [3:0]  c_BURST_SAT         = 4'hF;

  logic [3:0]  r_burst_cnt;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;
  logic        w_err;
  logic [31:0] w_sel_addr;
  logic [31:0] w_rdata;
  logic        r_m0_rvalid;
  logic        r_m1_rvalid;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;

  always_comb begin
    w_gnt0     = m0_req & (~m1_req | (r_burst_cnt < c_MAX_BURST));
    w_gnt1     = m1_req & ~w_gnt0;
    w_any_gnt  = w_gnt0 | w_gnt1;
    w_sel_addr = c_ZERO_WORD;
    if (w_gnt0) begin
      w_sel_addr = m0_addr;
    end else if (w_gnt1) begin
      w_sel_addr = m1_addr;
    end
  end

`ifdef INST_ROM_ARB_ADDR_CHECK_EN
  assign w_err = w_any_gnt &
                 ((w_sel_addr[1:0] != 2'b00) |
                  (|w_sel_addr[31:c_INST_MEM_NUM_LOG2+2]));
`else
  assign w_err = 1'b0;
`endif

  assign w_rdata  = w_err ? c_ZERO_WORD : rom_inst;
  assign m0_gnt   = w_gnt0;
  assign m1_gnt   = w_gnt1;
  assign rom_ce   = (w_any_gnt & ~w_err) ? c_CHIP_ENABLE : c_CHIP_DISABLE;
  assign rom_addr = w_sel_addr;

  // Counts fetch wins while the debug port waits; any debug win or idle debug clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_burst_cnt <= 4'd0;
    end else if (!m1_req || w_gnt1) begin
      r_burst_cnt <= 4'd0;
    end else if (w_gnt0 && (r_burst_cnt != c_BURST_SAT)) begin
      r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= c_ZERO_WORD;
      r_m1_rdata  <= c_ZERO_WORD;
    end else begin
      r_m0_rvalid <= w_gnt0;
      r_m1_rvalid <= w_gnt1;
      if (w_gnt0) begin
        r_m0_rdata <= w_rdata;
      end
      if (w_gnt1) begin
        r_m1_rdata <= w_rdata;
      end
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

`ifdef INST_ROM_ARB_ADDR_CHECK_EN
  logic r_m0_err;
  logic r_m1_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_m0_err <= w_err;
      end
      if (w_gnt1) begin
        r_m1_err <= w_err;
      end
    end
  end

  assign m0_err = r_m0_err;
  assign m1_err = r_m1_err;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_rom_arbiter
// Purpose  : Directed self-checking bench for inst_rom_arbiter (MAX_BURST = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROM model: word 3 holds a known instruction, other words encode their index.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [16:0] idx;
    idx = a[18:2];
    if (idx == 17'd3) return 32'h3401_1100;
    return 32'h8000_0000 | {15'd0, idx};
  endfunction

  assign rom_inst = rom_word(rom_addr);

  inst_rom_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst)
  );

  task automatic test_reset();
    rst = 1'b0; m0_req = 1'b1; m0_addr = 32'h8; m1_req = 1'b1; m1_addr = 32'h14;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rvalid: got m0=%b m1=%b, expected 0 0", m0_rvalid, m1_rvalid);
    end
    n_checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got m0=%h m1=%h, expected 0 0", m0_rdata, m1_rdata);
    end
    n_checks++;
    if (m0_err !== 1'b0 || m1_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got m0=%b m1=%b, expected 0 0", m0_err, m1_err);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_gnt: got g0=%b g1=%b, expected 1 0", m0_gnt, m1_gnt);
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    n_checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'h8000_0002) begin
      n_fail++; $display("FAIL reset_first_resp: got v0=%b v1=%b d0=%h, expected 1 0 80000002",
                         m0_rvalid, m1_rvalid, m0_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    m0_req = 1'b1; m0_addr = 32'h0000_000C;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || rom_ce !== 1'b1 || rom_addr !== 32'h0000_000C) begin
      n_fail++; $display("FAIL fetch_gnt: got gnt=%b ce=%b addr=%h, expected 1 1 0000000c",
                         m0_gnt, rom_ce, rom_addr);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    n_checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h3401_1100 || m1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_resp: got v0=%b d0=%h v1=%b, expected 1 34011100 0",
                         m0_rvalid, m0_rdata, m1_rvalid);
    end
    #1;
    n_checks++;
    if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL idle_outputs: got ce=%b addr=%h g0=%b g1=%b, expected 0 0 0 0",
                         rom_ce, rom_addr, m0_gnt, m1_gnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rvalid_drop: got %b, expected 0", m0_rvalid);
    end
  endtask

  task automatic test_starvation();
    bit e1;
    m0_addr = 32'h10; m1_addr = 32'h20; m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      e1 = ((i % 5) == 4);
      #1;
      n_checks++;
      if (m0_gnt !== ~e1 || m1_gnt !== e1) begin
        n_fail++; $display("FAIL starve_gnt[%0d]: got g0=%b g1=%b, expected %b %b",
                           i, m0_gnt, m1_gnt, ~e1, e1);
      end
      @(posedge clk); #1;
      n_checks++;
      if (m0_rvalid !== ~e1 || m1_rvalid !== e1) begin
        n_fail++; $display("FAIL starve_rvalid[%0d]: got v0=%b v1=%b, expected %b %b",
                           i, m0_rvalid, m1_rvalid, ~e1, e1);
      end
      n_checks++;
      if (e1 ? (m1_rdata !== rom_word(32'h20)) : (m0_rdata !== rom_word(32'h10))) begin
        n_fail++; $display("FAIL starve_rdata[%0d]: got d0=%h d1=%h, expected %h on port %0d",
                           i, m0_rdata, m1_rdata, e1 ? rom_word(32'h20) : rom_word(32'h10), e1);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cancel();
    bit m1r [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    bit e1  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [31:0] a0;
    m1_addr = 32'h24;
    for (int i = 0; i < 8; i++) begin
      a0 = 32'h40 + 32'(4 * i);
      m0_req = 1'b1; m0_addr = a0; m1_req = m1r[i];
      #1;
      n_checks++;
      if (m0_gnt !== ~e1[i] || m1_gnt !== e1[i]) begin
        n_fail++; $display("FAIL cancel_gnt[%0d]: got g0=%b g1=%b, expected %b %b",
                           i, m0_gnt, m1_gnt, ~e1[i], e1[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (m0_rvalid !== ~e1[i] || m1_rvalid !== e1[i]) begin
        n_fail++; $display("FAIL cancel_rvalid[%0d]: got v0=%b v1=%b, expected %b %b",
                           i, m0_rvalid, m1_rvalid, ~e1[i], e1[i]);
      end
      n_checks++;
      if (e1[i] ? (m1_rdata !== rom_word(32'h24)) : (m0_rdata !== rom_word(a0))) begin
        n_fail++; $display("FAIL cancel_rdata[%0d]: got d0=%h d1=%h, expected %h",
                           i, m0_rdata, m1_rdata, e1[i] ? rom_word(32'h24) : rom_word(a0));
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h30;
    #1;
    n_checks++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midrst_gnt: got %b, expected 1", m1_gnt);
    end
    #2;
    rst = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_in_reset: got v1=%b d1=%h, expected 0 0", m1_rvalid, m1_rdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_after: got v0=%b v1=%b d0=%h d1=%h, expected 0 0 0 0",
                         m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_addr_check();
    bit          port [3] = '{0, 0, 1};
    logic [31:0] addr [3] = '{32'h0000_0006, 32'h0008_0000, 32'h0000_0021};
    logic        x_ce, x_err, g, v, er;
    logic [31:0] x_d, d;
    for (int i = 0; i < 3; i++) begin
`ifdef INST_ROM_ARB_ADDR_CHECK_EN
      x_ce = 1'b0; x_err = 1'b1; x_d = 32'h0;
`else
      x_ce = 1'b1; x_err = 1'b0; x_d = rom_word(addr[i]);
`endif
      m0_req = ~port[i]; m1_req = port[i];
      m0_addr = addr[i]; m1_addr = addr[i];
      #1;
      g = port[i] ? m1_gnt : m0_gnt;
      n_checks++;
      if (g !== 1'b1 || rom_ce !== x_ce) begin
        n_fail++; $display("FAIL addrchk_ce[%0d]: got gnt=%b ce=%b, expected 1 %b", i, g, rom_ce, x_ce);
      end
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
      v  = port[i] ? m1_rvalid : m0_rvalid;
      er = port[i] ? m1_err    : m0_err;
      d  = port[i] ? m1_rdata  : m0_rdata;
      n_checks++;
      if (v !== 1'b1 || er !== x_err || d !== x_d) begin
        n_fail++; $display("FAIL addrchk_resp[%0d]: got v=%b err=%b d=%h, expected 1 %b %h",
                           i, v, er, d, x_err, x_d);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_addr = 32'h0; m1_addr = 32'h0;
    test_reset();
    test_single_fetch();
    test_starvation();
    test_cancel();
    test_mid_reset();
    test_addr_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/inst_rom_arbiter.md
# inst_rom_arbiter

Arbitrates the single instruction ROM read port between two requesters: the IF-stage fetch unit (port 0) and the debug/boot-loader read port (port 1). Each cycle it grants at most one request, drives the ROM's `ce`/`addr`, and returns the registered instruction word with a valid pulse one cycle later. Port 0 has fixed priority, bounded by a starvation limit that guarantees port 1 progress. It sits between `if_id`/`pc_reg` plus the debug unit on one side and `inst_rom` on the other.

## Interface
Parameters:
- `MAX_BURST`, 4: maximum consecutive port-0 grants while port 1 is requesting; range 1–15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; one clock domain only.
- `m0_req`  in  1  fetch request; held high until granted.
- `m0_addr`  in  `InstAddrBus`  fetch byte address.
- `m0_gnt`  out  1  combinational grant; the address is consumed in this cycle.
- `m0_rvalid`  out  1  read data valid, one cycle after `m0_gnt`.
- `m0_rdata`  out  `InstBus`  returned instruction.
- `m0_err`  out  1  error response qualifier, valid with `m0_rvalid`.
- `m1_req`, `m1_addr`, `m1_gnt`, `m1_rvalid`, `m1_rdata`, `m1_err`: same definitions for the debug port.
- `rom_ce`  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr`  out  `InstAddrBus`  address to ROM, equal to the granted requester's address.
- `rom_inst`  in  `InstBus`  combinational ROM output.

## Operation
- Grant decision is combinational from `m0_req`, `m1_req`, and the starvation counter `burst_cnt` (4 bits).
- Only `m1_req`: grant port 1.
- Only `m0_req`: grant port 0.
- Both requesting:
  - grant port 0 if `burst_cnt < MAX_BURST`;
  - otherwise grant port 1.
- Neither requesting: no grant, `rom_ce = ChipDisable`, and `rom_addr = ZeroWord`.
- `rom_ce` is asserted exactly when a grant is issued and the access is not an error access (see Configuration).
- `burst_cnt` update:
  - +1 on a port-0 grant while `m1_req` is high, saturating at 15;
  - cleared on any port-1 grant or any cycle with `m1_req` low;
  - otherwise held.
- Response register, loaded on the edge after a grant:
  - `rdata` ← `rom_inst`, or `ZeroWord` for an error access;
  - `err` ← error flag;
  - `rvalid` of the granted port ← 1, other port ← 0.
- `rdata` and `err` of the non-granted port hold their last values; they are meaningful only with `rvalid`.
- Requesters must keep `req` and `addr` stable until `gnt`. Dropping `req` before `gnt` is legal and cancels the request without side effects.

## Timing
- Grant latency is 0 cycles (combinational); data latency is 1 cycle after the grant edge.
- Throughput is one access per cycle. Back-to-back grants to the same port give `rvalid` high on consecutive cycles.
- With both ports continuously requesting and `MAX_BURST = N`, grants follow the repeating pattern: N × port 0, then 1 × port 1.
- Values after reset assertion:
  - `m*_rvalid = 0`, `m*_rdata = ZeroWord`, `m*_err = 0`, `burst_cnt = 0`;
  - `m*_gnt`, `rom_ce` and `rom_addr` follow the combinational rules and are inactive while no request is present.
- Reset during an in-flight access drops that response: no `rvalid` is produced after reset deasserts.
- Grants are combinational and therefore are not gated by `rst`. A requester must not treat a grant during reset as accepted.

## Configuration
- `INST_ROM_ARB_ADDR_CHECK_EN` defined: a granted address is an error access if either condition holds:
  - `addr[1:0] != 2'b00` (misaligned);
  - `addr[31:InstMemNumLog2+2]` is nonzero (beyond the ROM).
- An error access is still granted and still counts for `burst_cnt`, but `rom_ce` stays `ChipDisable` and the response is `rdata = ZeroWord`, `err = 1`.
- Macro undefined:
  - no checking; every grant asserts `rom_ce`;
  - `m0_err` and `m1_err` are constant 0;
  - `rom_addr` is passed through unmodified, so the ROM ignores bits [1:0] and the high bits.

## Test plan
- Reset: hold `rst = 0` with both requests high → all `rvalid = 0` and `rdata = 0`. Release reset → first grant goes to port 0, and `m0_rvalid` rises one cycle later.
- Single fetch: ROM word[3] = 32'h34011100; `m0_addr = 32'h0000000C` for one granted cycle → next cycle `m0_rvalid = 1`, `m0_rdata = 32'h34011100`, `m1_rvalid = 0`.
- Starvation bound: `MAX_BURST = 4`, both ports requesting continuously for 15 cycles → grant sequence 0,0,0,0,1,0,0,0,0,1,…, and `burst_cnt` returns to 0 after each port-1 grant.
- Cancel and counter clear: port 1 drops `m1_req` after 2 losing cycles → `burst_cnt` clears, no `m1_rvalid` is produced, and port-0 data stays correct.
- Mid-access reset: grant port 1, then assert `rst` before the next edge → `m1_rvalid` stays 0 and no stale data appears after release.
- With `INST_ROM_ARB_ADDR_CHECK_EN`:
  - `m0_addr = 32'h00000006` → `rom_ce = 0`, next cycle `m0_err = 1`, `m0_rdata = 0`;
  - `m0_addr = 32'h00080000` → same error response;
  - without the macro, the same addresses return the ROM data and `err = 0`.
